// File: rtl/act_layer_sched_pkg.sv
// Shared PE scheduler constants: activation count, ping-pong direction
// encodings and the 3-bit layer sequencer state encoding.
package act_layer_sched_pkg;

    localparam int PE_ACT_NO = 16;
    localparam int PE_ACT_W  = $clog2(PE_ACT_NO);

    localparam logic ACT_DIR_0 = 1'b0;
    localparam logic ACT_DIR_1 = 1'b1;

    typedef enum logic [2:0] {
        SCHED_IDLE  = 3'd0,
        SCHED_CLEAR = 3'd1,
        SCHED_SCAN  = 3'd2,
        SCHED_DRAIN = 3'd3,
        SCHED_SWAP  = 3'd4
    } sched_state_t;

endpackage

// File: rtl/act_layer_sched_if.sv
// Activation presentation handshake between the scheduler and the MAC
// datapath: act_valid/act_idx from master, act_ready from slave.
interface act_layer_sched_if #(
    parameter int ADDR_W = 4
) ();

    logic              act_valid;
    logic              act_ready;
    logic [ADDR_W-1:0] act_idx;

    modport master (
        output act_valid,
        output act_idx,
        input  act_ready
    );

    modport slave (
        input  act_valid,
        input  act_idx,
        output act_ready
    );

endinterface

// File: rtl/act_layer_sched_prio_enc.sv
// act_prio_enc: combinational lowest-index-wins priority encoder.
// Ports: mask (ACT_NO) in; idx (ADDR_W) and any out.
module act_prio_enc #(
    parameter int ACT_NO = 16,
    parameter int ADDR_W = 4
) (
    input  logic [ACT_NO-1:0] mask,
    output logic [ADDR_W-1:0] idx,
    output logic              any
);

    always_comb begin
        idx = '0;
        any = |mask;
        for (int i = ACT_NO - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = ADDR_W'(i);
            end
        end
    end

endmodule

// File: rtl/act_layer_sched.sv
// act_layer_sched: per-layer sequencer for the ping-pong activation files.
// Ports: clk, rst_n, layer_start, layer_num_act, in_act_zeros, mac_busy in;
// act (master: act_valid/act_idx out, act_ready in); dir, out_act_clear,
// in_act_read_en, in_act_read_addr, busy, layer_done out.
// Build option: ZERO_SKIP_EN skips activations flagged zero in in_act_zeros.
module act_layer_sched
    import act_layer_sched_pkg::*;
#(
    parameter int ACT_NO = PE_ACT_NO,
    parameter int ADDR_W = $clog2(ACT_NO)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              layer_start,
    input  logic [ADDR_W:0]   layer_num_act,
    input  logic [ACT_NO-1:0] in_act_zeros,
    input  logic              mac_busy,
    act_layer_sched_if.master act,
    output logic              dir,
    output logic              out_act_clear,
    output logic              in_act_read_en,
    output logic [ADDR_W-1:0] in_act_read_addr,
    output logic              busy,
    output logic              layer_done
);

    sched_state_t      state, state_nxt;
    logic [ACT_NO-1:0] pend;
    logic [ACT_NO-1:0] sel;
    logic [ADDR_W-1:0] nxt;
    logic              any;
    logic              issue;
    logic              slot_free;
    logic              valid_q;
    logic [ADDR_W-1:0] idx_q;
    logic              dir_q;

    act_prio_enc #(
        .ACT_NO (ACT_NO),
        .ADDR_W (ADDR_W)
    ) u_prio (
        .mask (pend),
        .idx  (nxt),
        .any  (any)
    );

    // Counts above ACT_NO saturate naturally: every i < ACT_NO is selected.
    always_comb begin
        sel = '0;
        for (int i = 0; i < ACT_NO; i++) begin
`ifdef ZERO_SKIP_EN
            sel[i] = ~in_act_zeros[i] & (int'(layer_num_act) > i);
`else
            sel[i] = (int'(layer_num_act) > i);
`endif
        end
    end

`ifndef ZERO_SKIP_EN
    logic unused_zeros;
    assign unused_zeros = ^in_act_zeros;
`endif

    // The presentation slot frees up when empty or being accepted now.
    assign slot_free = !valid_q || act.act_ready;
    assign issue     = (state == SCHED_SCAN) && any && slot_free;

    always_comb begin
        state_nxt        = state;
        out_act_clear    = 1'b0;
        layer_done       = 1'b0;
        in_act_read_en   = issue;
        in_act_read_addr = issue ? nxt : '0;
        busy             = (state != SCHED_IDLE);
        unique case (state)
            SCHED_IDLE: begin
                if (layer_start) state_nxt = SCHED_CLEAR;
            end
            SCHED_CLEAR: begin
                out_act_clear = 1'b1;
                state_nxt     = SCHED_SCAN;
            end
            SCHED_SCAN: begin
                if (!any && slot_free) state_nxt = SCHED_DRAIN;
            end
            SCHED_DRAIN: begin
                if (!mac_busy) state_nxt = SCHED_SWAP;
            end
            SCHED_SWAP: begin
                layer_done = 1'b1;
                state_nxt  = SCHED_IDLE;
            end
            default: state_nxt = SCHED_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SCHED_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else if (state == SCHED_CLEAR) begin
            pend <= sel;
        end else if (issue) begin
            pend <= pend & ~({{(ACT_NO-1){1'b0}}, 1'b1} << nxt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
        end else if (issue) begin
            valid_q <= 1'b1;
            idx_q   <= nxt;
        end else if (act.act_ready) begin
            valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q <= ACT_DIR_0;
        end else if (state == SCHED_SWAP) begin
            dir_q <= ~dir_q;
        end
    end

    assign act.act_valid = valid_q;
    assign act.act_idx   = idx_q;
    assign dir           = dir_q;

endmodule

// File: tb/tb_act_layer_sched.sv
// Directed table-driven bench for act_layer_sched; works with or without
// ZERO_SKIP_EN (expected masks for both builds are in the table).
module tb_act_layer_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        layer_start = 1'b0;
    logic [4:0]  layer_num_act = '0;
    logic [15:0] in_act_zeros = '0;
    logic        mac_busy = 1'b0;
    logic        dir;
    logic        out_act_clear;
    logic        in_act_read_en;
    logic [3:0]  in_act_read_addr;
    logic        busy;
    logic        layer_done;

    act_layer_sched_if #(.ADDR_W(4)) act ();

    act_layer_sched #(.ACT_NO(16), .ADDR_W(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .layer_start      (layer_start),
        .layer_num_act    (layer_num_act),
        .in_act_zeros     (in_act_zeros),
        .mac_busy         (mac_busy),
        .act              (act.master),
        .dir              (dir),
        .out_act_clear    (out_act_clear),
        .in_act_read_en   (in_act_read_en),
        .in_act_read_addr (in_act_read_addr),
        .busy             (busy),
        .layer_done       (layer_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  num;
        logic [15:0] zeros;
        logic [15:0] m_zs;
        logic [15:0] m_nz;
        int          stall_idx;
        int          stall_n;
        int          mb;
        bit          extra;
    } vec_t;

    vec_t tbl [7];
    int   n_chk = 0;
    int   n_fail = 0;
    logic exp_dir = 1'b0;

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    function automatic int lowest(input logic [15:0] m);
        for (int i = 0; i < 16; i++) begin
            if (m[i]) return i;
        end
        return -1;
    endfunction

    task automatic run_layer(input vec_t v);
        logic [15:0] exp_m, acc_rem, iss_rem;
        int cyc, stall_left, first_a, last_a, n_clr, pop, done_cyc, mb_cnt;
        int lo;
        bit prev_mb, done, stalling, prev_stall, exp_rd;
`ifdef ZERO_SKIP_EN
        exp_m = v.m_zs;
`else
        exp_m = v.m_nz;
`endif
        acc_rem = exp_m;
        iss_rem = exp_m;
        pop = $countones(exp_m);
        stall_left = v.stall_n;
        first_a = -1;
        last_a = -1;
        n_clr = 0;
        done_cyc = -1;
        mb_cnt = v.mb;
        done = 0;
        prev_stall = 0;
        @(negedge clk);
        layer_start = 1'b1;
        layer_num_act = v.num;
        in_act_zeros = v.zeros;
        act.act_ready = 1'b1;
        mac_busy = (v.mb > 0);
        prev_mb = mac_busy;
        cyc = 0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            layer_start = 1'b0;
            if (cyc == 2) in_act_zeros = ~v.zeros;
            if (v.extra && cyc == 3) layer_start = 1'b1;
            stalling = act.act_valid && (int'(act.act_idx) == v.stall_idx)
                       && stall_left > 0;
            if (stalling) stall_left--;
            act.act_ready = !stalling;
            if (acc_rem == 0 && mb_cnt > 0) mb_cnt--;
            mac_busy = (v.mb > 0) && (acc_rem != 0 || mb_cnt > 0);
            #1;
            if (cyc == 1) chk("clear_pulse", out_act_clear, 1);
            if (out_act_clear) n_clr++;
            if (prev_stall)
                chk("stall_held", {act.act_valid, act.act_idx},
                    {1'b1, 4'(v.stall_idx)});
            exp_rd = (cyc >= 2) && (iss_rem != 0) &&
                     (!act.act_valid || act.act_ready);
            chk("read_en", in_act_read_en, exp_rd);
            if (in_act_read_en) begin
                lo = lowest(iss_rem);
                chk("issue_addr", in_act_read_addr, lo);
                if (lo >= 0) iss_rem[lo] = 1'b0;
            end
            if (act.act_valid && act.act_ready) begin
                lo = lowest(acc_rem);
                chk("accept_idx", act.act_idx, lo);
                if (lo >= 0) acc_rem[lo] = 1'b0;
                if (first_a < 0) first_a = cyc;
                last_a = cyc;
            end
            if (exp_m == 0) chk("no_valid_empty", act.act_valid, 0);
            if (layer_done) begin
                chk("done_after_mac_idle", prev_mb, 0);
                chk("dir_at_done", dir, exp_dir);
                chk("all_accepted", acc_rem, 0);
                done = 1;
                done_cyc = cyc;
                if (v.extra) layer_start = 1'b1;
            end
            prev_mb = mac_busy;
            prev_stall = stalling;
        end
        chk("layer_timeout", done, 1);
        chk("clear_count", n_clr, 1);
        if (v.stall_n > 0) chk("stalls_applied", stall_left, 0);
        if (v.stall_n == 0 && pop > 0)
            chk("back_to_back", last_a - first_a, pop - 1);
        if (exp_m == 0 && v.mb == 0) chk("empty_latency", done_cyc, 4);
        @(negedge clk);
        layer_start = 1'b0;
        #1;
        exp_dir = ~exp_dir;
        chk("dir_toggled", dir, exp_dir);
        chk("idle_after_swap", busy, 0);
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("no_queued_start", {busy, layer_done}, 2'b00);
        end
    endtask

    initial begin
        tbl[0] = '{5'd8,  16'hFF5A, 16'h00A5, 16'h00FF, -1, 0, 2, 1'b0};
        tbl[1] = '{5'd8,  16'hFF5A, 16'h00A5, 16'h00FF,  2, 3, 0, 1'b0};
        tbl[2] = '{5'd0,  16'h0000, 16'h0000, 16'h0000, -1, 0, 0, 1'b0};
        tbl[3] = '{5'd16, 16'hFFFF, 16'h0000, 16'hFFFF, -1, 0, 0, 1'b0};
        tbl[4] = '{5'd20, 16'hFFFF, 16'h0000, 16'hFFFF, -1, 0, 0, 1'b0};
        tbl[5] = '{5'd3,  16'h0000, 16'h0007, 16'h0007, -1, 0, 1, 1'b1};
        tbl[6] = '{5'd20, 16'h0F0F, 16'hF0F0, 16'hFFFF,  4, 2, 1, 1'b1};
        act.act_ready = 1'b1;

        #12;
        chk("rst_dir", dir, 0);
        chk("rst_outs", {busy, layer_done, out_act_clear, in_act_read_en,
                         act.act_valid}, 5'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_layer(tbl[i]);
        end

        if (exp_dir == 1'b0) run_layer(tbl[5]);
        @(negedge clk);
        layer_start = 1'b1;
        layer_num_act = 5'd16;
        in_act_zeros = 16'h0000;
        act.act_ready = 1'b0;
        mac_busy = 1'b0;
        @(negedge clk);
        layer_start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("pre_reset_valid", act.act_valid, 1);
        chk("pre_reset_dir", dir, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", act.act_valid, 0);
        chk("rst_async_busy", busy, 0);
        chk("rst_async_rd", in_act_read_en, 0);
        chk("rst_async_dir", dir, 0);
        @(negedge clk);
        rst_n = 1'b1;
        act.act_ready = 1'b1;
        exp_dir = 1'b0;
        run_layer(tbl[0]);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
